radar_pulse_sequencer: RTL

//  Sequences per-pulse capture into the header-packing sample buffer. On each radar trigger edge it

---
 rtl/radar_pulse_sequencer_pkg.sv | 14 +
 rtl/trigger_edge_detect.sv | 27 ++
 rtl/radar_pulse_sequencer.sv | 120 ++++++++++++
 3 files changed

// File: rtl/radar_pulse_sequencer_pkg.sv
// rtl/radar_pulse_sequencer_pkg.sv - shared widths and state encoding for the pulse sequencer
package radar_pulse_sequencer_pkg;

   localparam int SEQ_CNT_W = 32;
   localparam int SEQ_NS_W  = 16;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_INIT    = 2'd1,
      ST_DELAY   = 2'd2,
      ST_CAPTURE = 2'd3
   } seq_state_t;

endpackage

// File: rtl/trigger_edge_detect.sv
// rtl/trigger_edge_detect.sv - two-flop synchroniser with rising-edge pulse
module trigger_edge_detect (
   input  logic clock,
   input  logic reset,
   input  logic async_in,
   output logic edge_pulse
);

   logic sync_1;
   logic sync_2;
   logic sync_prev;

   always_ff @(posedge clock) begin
      if (reset) begin
         sync_1    <= 1'b0;
         sync_2    <= 1'b0;
         sync_prev <= 1'b0;
      end else begin
         sync_1    <= async_in;
         sync_2    <= sync_1;
         sync_prev <= sync_2;
      end
   end

   assign edge_pulse = sync_2 & ~sync_prev;

endmodule

// File: rtl/radar_pulse_sequencer.sv
// rtl/radar_pulse_sequencer.sv - per-pulse header latch, delay skip and sample gating
module radar_pulse_sequencer
   import radar_pulse_sequencer_pkg::*;
#(
   parameter int CNT_W  = SEQ_CNT_W,
   parameter int NS_W   = SEQ_NS_W,
   parameter int META_W = 3 * CNT_W + 2 * NS_W
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              enable,
   input  logic              trigger,
   input  logic              strobe_in,
   input  logic [CNT_W-1:0]  azimuth,
   input  logic [NS_W-1:0]   n_samples,
   input  logic [NS_W-1:0]   delay,
   output logic [META_W-1:0] meta_data,
   output logic              hdr_init,
   output logic              gate_strobe,
   output logic              busy,
   output logic              done
);

   localparam logic [NS_W-1:0] MISSED_MAX = '1;

   seq_state_t       state;
   logic             trig_edge;
   logic [CNT_W-1:0] clk_cnt;
   logic [CNT_W-1:0] trig_cnt;
   logic [NS_W-1:0]  missed_cnt;
   logic [NS_W-1:0]  ns_lat;
   logic [NS_W-1:0]  step_cnt;

   trigger_edge_detect u_trigger_edge (
      .clock      (clock),
      .reset      (reset),
      .async_in   (trigger),
      .edge_pulse (trig_edge)
   );

   always_ff @(posedge clock) begin
      if (reset) clk_cnt <= '0;
      else       clk_cnt <= clk_cnt + 1'b1;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= ST_IDLE;
         meta_data  <= '0;
         trig_cnt   <= '0;
         missed_cnt <= '0;
         ns_lat     <= '0;
         step_cnt   <= '0;
         hdr_init   <= 1'b0;
         done       <= 1'b0;
      end else begin
         hdr_init <= 1'b0;
         done     <= 1'b0;
         if (trig_edge && (!enable || state != ST_IDLE))
            missed_cnt <= (missed_cnt == MISSED_MAX) ? missed_cnt : missed_cnt + 1'b1;
         if (!enable) begin
            state <= ST_IDLE;
         end else begin
            unique case (state)
               ST_IDLE: begin
                  if (trig_edge) begin
                     trig_cnt   <= trig_cnt + 1'b1;
                     meta_data  <= {missed_cnt, n_samples, azimuth, clk_cnt, trig_cnt + 1'b1};
                     missed_cnt <= '0;
                     ns_lat     <= n_samples;
                     step_cnt   <= delay;
                     hdr_init   <= 1'b1;
                     state      <= ST_INIT;
                  end
               end
               ST_INIT: begin
                  if (step_cnt != '0) begin
                     state <= ST_DELAY;
                  end else if (ns_lat != '0) begin
                     step_cnt <= ns_lat;
                     state    <= ST_CAPTURE;
                  end else begin
                     done  <= 1'b1;
                     state <= ST_IDLE;
                  end
               end
               ST_DELAY: begin
                  if (strobe_in) begin
                     if (step_cnt != NS_W'(1)) begin
                        step_cnt <= step_cnt - 1'b1;
                     end else if (ns_lat != '0) begin
                        step_cnt <= ns_lat;
                        state    <= ST_CAPTURE;
                     end else begin
                        done  <= 1'b1;
                        state <= ST_IDLE;
                     end
                  end
               end
               ST_CAPTURE: begin
                  // The strobe that empties the count is itself gated through.
                  if (strobe_in) begin
                     if (step_cnt != NS_W'(1)) begin
                        step_cnt <= step_cnt - 1'b1;
                     end else begin
                        done  <= 1'b1;
                        state <= ST_IDLE;
                     end
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

   assign gate_strobe = enable && (state == ST_CAPTURE) && strobe_in;
   assign busy        = enable && (state != ST_IDLE);

endmodule
